// File: rtl/msg_parser_pkg.sv
// msg_parser_pkg
// Shared definitions for the message word parser:
//   - state_e       : parser FSM state encoding (IDLE, PAYLOAD, DROP)
//   - SYNC_DEFAULT  : default header sync byte
//   - HDR_*_LSB     : bit offsets of the header fields inside a 64-bit word
//   - WORDS_W       : width of the payload word counter
//   - keep_mask()   : valid-byte mask for the final payload beat
package msg_parser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'h7E;

  // Header layout: [63:56] sync, [55:48] type, [47:32] length, [31:0] sequence
  localparam int HDR_SYNC_LSB = 56;
  localparam int HDR_TYPE_LSB = 48;
  localparam int HDR_LEN_LSB  = 32;
  localparam int HDR_SEQ_LSB  = 0;

  // ceil(65535/8) = 8192 still fits in 14 bits
  localparam int WORDS_W = 14;

  // rem = len[2:0]; a zero remainder means the last word is completely full
  function automatic logic [7:0] keep_mask(input logic [2:0] rem);
    logic [8:0] w_ones;
    w_ones = (9'd1 << rem) - 9'd1;
    keep_mask = (rem == 3'd0) ? 8'hFF : w_ones[7:0];
  endfunction

endpackage

// File: rtl/msg_out_stage.sv
// msg_out_stage
// Single register stage for the payload stream. A beat loaded here stays
// on the outputs, untouched, until the consumer takes it.
//
// Valid/ready: a beat transfers on a rising edge where o_valid & i_ready.
// While o_valid & ~i_ready every output holds. The parent only asserts
// i_load when the register is empty or is being emptied this cycle
// (~o_valid | i_ready), so a held beat can never be overwritten.
//
// Ports:
//   fifo_clk, fifo_reset    clock, asynchronous active-high reset
//   i_load                  capture a new beat this cycle
//   i_data/i_keep/i_sop/i_eop  beat contents
//   i_type/i_len/i_seq/i_gap   message fields travelling with the beat
//   i_ready                 downstream accepts the current beat
//   o_*                     registered copies of the above
module msg_out_stage #(
  parameter int WordWidth = 64
) (
  input  logic                 fifo_clk,
  input  logic                 fifo_reset,
  input  logic                 i_load,
  input  logic [WordWidth-1:0] i_data,
  input  logic [7:0]           i_keep,
  input  logic                 i_sop,
  input  logic                 i_eop,
  input  logic [7:0]           i_type,
  input  logic [15:0]          i_len,
  input  logic [31:0]          i_seq,
  input  logic                 i_gap,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [WordWidth-1:0] o_data,
  output logic [7:0]           o_keep,
  output logic                 o_sop,
  output logic                 o_eop,
  output logic [7:0]           o_type,
  output logic [15:0]          o_len,
  output logic [31:0]          o_seq,
  output logic                 o_gap
);

  logic                 r_valid;
  logic [WordWidth-1:0] r_data;
  logic [7:0]           r_keep;
  logic                 r_sop;
  logic                 r_eop;
  logic [7:0]           r_type;
  logic [15:0]          r_len;
  logic [31:0]          r_seq;
  logic                 r_gap;

  // Header fields ride with each beat so that a following header, popped
  // while this message's eop is still held, cannot disturb them.
  always_ff @(posedge fifo_clk or posedge fifo_reset) begin
    if (fifo_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_type  <= '0;
      r_len   <= '0;
      r_seq   <= '0;
      r_gap   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
      r_type  <= i_type;
      r_len   <= i_len;
      r_seq   <= i_seq;
      r_gap   <= i_gap;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_gap   <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_sop   = r_sop;
  assign o_eop   = r_eop;
  assign o_type  = r_type;
  assign o_len   = r_len;
  assign o_seq   = r_seq;
  assign o_gap   = r_gap;

endmodule

// File: rtl/msg_word_parser.sv
// msg_word_parser
// Frames 64-bit words from a show-ahead FIFO into messages. The first word
// of each message is a header {sync, type, len, seq}; ceil(len/8) payload
// words follow. Good messages go out on a valid/ready stream; a bad sync
// byte costs one word, a bad length drops the whole message.
//
// Build option: define PARSER_STATS_EN to enable the stat_msgs/stat_errs
// counters; without it both outputs are tied to zero.
//
// Ports:
//   fifo_clk, fifo_reset     clock, asynchronous active-high reset
//   fifo_empty, fifo_r_data  upstream FIFO state and head word
//   fifo_rd                  pop the head word (combinational)
//   out_valid/out_ready      payload stream handshake
//   out_data/keep/sop/eop    payload beat
//   msg_type/len/seq         header fields, stable from sop to eop
//   seq_gap                  sequence discontinuity, qualified by out_sop
//   err_sync, err_len        one-cycle error pulses
//   stat_msgs, stat_errs     statistics counters
//   dbg_state                current FSM state
module msg_word_parser
  import msg_parser_pkg::*;
#(
  parameter int         WordWidth = 64,
  parameter int         MaxBytes  = 1500,
  parameter logic [7:0] SyncByte  = SYNC_DEFAULT,
  parameter int         CntWidth  = 32
) (
  input  logic                 fifo_clk,
  input  logic                 fifo_reset,
  input  logic                 fifo_empty,
  input  logic [WordWidth-1:0] fifo_r_data,
  output logic                 fifo_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WordWidth-1:0] out_data,
  output logic [7:0]           out_keep,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [7:0]           msg_type,
  output logic [15:0]          msg_len,
  output logic [31:0]          msg_seq,
  output logic                 seq_gap,
  output logic                 err_sync,
  output logic                 err_len,
  output logic [CntWidth-1:0]  stat_msgs,
  output logic [CntWidth-1:0]  stat_errs,
  output logic [1:0]           dbg_state
);

  localparam logic [15:0] MAX_LEN = 16'(MaxBytes);

  state_e             r_state;
  logic [WORDS_W-1:0] r_words_left;
  logic               r_first;
  logic [7:0]         r_type;
  logic [15:0]        r_len;
  logic [31:0]        r_seq;
  logic               r_gap;
  logic               r_seq_seen;
  logic [31:0]        r_exp_seq;
  logic               r_err_sync;
  logic               r_err_len;

  logic [7:0]         w_sync;
  logic [7:0]         w_type;
  logic [15:0]        w_len;
  logic [31:0]        w_seq;
  logic [WORDS_W-1:0] w_words;
  logic               w_len_bad;
  logic               w_pop;
  logic               w_beat_load;
  logic               w_last;
  logic [7:0]         w_keep;

  assign w_sync = fifo_r_data[HDR_SYNC_LSB +: 8];
  assign w_type = fifo_r_data[HDR_TYPE_LSB +: 8];
  assign w_len  = fifo_r_data[HDR_LEN_LSB  +: 16];
  assign w_seq  = fifo_r_data[HDR_SEQ_LSB  +: 32];

  // ceil(len/8) without a wide intermediate
  assign w_words   = {1'b0, w_len[15:3]} + {{(WORDS_W-1){1'b0}}, |w_len[2:0]};
  assign w_len_bad = (w_len == 16'd0) || (w_len > MAX_LEN);

  // Headers and dropped words never touch the output register, so they pop
  // regardless of out_ready; payload pops need a free output slot.
  always_comb begin
    w_pop = 1'b0;
    if (!fifo_reset && !fifo_empty) begin
      case (r_state)
        ST_IDLE, ST_DROP: w_pop = 1'b1;
        ST_PAYLOAD:       w_pop = ~out_valid | out_ready;
        default:          w_pop = 1'b0;
      endcase
    end
  end

  assign fifo_rd     = w_pop;
  assign w_beat_load = w_pop && (r_state == ST_PAYLOAD);
  assign w_last      = (r_words_left == {{(WORDS_W-1){1'b0}}, 1'b1});
  assign w_keep      = w_last ? keep_mask(r_len[2:0]) : 8'hFF;

  always_ff @(posedge fifo_clk or posedge fifo_reset) begin
    if (fifo_reset) begin
      r_state      <= ST_IDLE;
      r_words_left <= '0;
      r_first      <= 1'b0;
      r_type       <= '0;
      r_len        <= '0;
      r_seq        <= '0;
      r_gap        <= 1'b0;
      r_seq_seen   <= 1'b0;
      r_exp_seq    <= '0;
      r_err_sync   <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      r_err_sync <= 1'b0;
      r_err_len  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            if (w_sync != SyncByte) begin
              r_err_sync <= 1'b1;
            end else if (w_len_bad) begin
              // len==0 has no words to skip, so it stays in IDLE
              r_err_len    <= 1'b1;
              r_words_left <= w_words;
              if (w_words != '0) r_state <= ST_DROP;
            end else begin
              r_type       <= w_type;
              r_len        <= w_len;
              r_seq        <= w_seq;
              // The first good message after reset has nothing to compare to
              r_gap        <= r_seq_seen && (w_seq != r_exp_seq);
              r_exp_seq    <= w_seq + 32'd1;
              r_seq_seen   <= 1'b1;
              r_words_left <= w_words;
              r_first      <= 1'b1;
              r_state      <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_pop) begin
            r_words_left <= r_words_left - {{(WORDS_W-1){1'b0}}, 1'b1};
            r_first      <= 1'b0;
            if (w_last) r_state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (w_pop) begin
            r_words_left <= r_words_left - {{(WORDS_W-1){1'b0}}, 1'b1};
            if (w_last) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  msg_out_stage #(
    .WordWidth(WordWidth)
  ) u_out_stage (
    .fifo_clk  (fifo_clk),
    .fifo_reset(fifo_reset),
    .i_load    (w_beat_load),
    .i_data    (fifo_r_data),
    .i_keep    (w_keep),
    .i_sop     (r_first),
    .i_eop     (w_last),
    .i_type    (r_type),
    .i_len     (r_len),
    .i_seq     (r_seq),
    .i_gap     (r_gap & r_first),
    .i_ready   (out_ready),
    .o_valid   (out_valid),
    .o_data    (out_data),
    .o_keep    (out_keep),
    .o_sop     (out_sop),
    .o_eop     (out_eop),
    .o_type    (msg_type),
    .o_len     (msg_len),
    .o_seq     (msg_seq),
    .o_gap     (seq_gap)
  );

  assign err_sync  = r_err_sync;
  assign err_len   = r_err_len;
  assign dbg_state = r_state;

`ifdef PARSER_STATS_EN
  logic [CntWidth-1:0] r_stat_msgs;
  logic [CntWidth-1:0] r_stat_errs;

  // A message counts once its eop beat is actually accepted downstream
  always_ff @(posedge fifo_clk or posedge fifo_reset) begin
    if (fifo_reset) begin
      r_stat_msgs <= '0;
      r_stat_errs <= '0;
    end else begin
      if (out_valid && out_ready && out_eop)
        r_stat_msgs <= r_stat_msgs + {{(CntWidth-1){1'b0}}, 1'b1};
      if (r_err_sync || r_err_len)
        r_stat_errs <= r_stat_errs + {{(CntWidth-1){1'b0}}, 1'b1};
    end
  end

  assign stat_msgs = r_stat_msgs;
  assign stat_errs = r_stat_errs;
`else
  assign stat_msgs = '0;
  assign stat_errs = '0;
`endif

endmodule

// File: tb/tb_msg_word_parser.sv
// tb_msg_word_parser
// Directed bench for msg_word_parser. An upstream show-ahead FIFO is
// modelled with a queue; a stream-level model turns each pushed word
// sequence into the expected payload beats and error counts.
module tb_msg_word_parser;

  localparam int BW = 131;

  logic        fifo_clk;
  logic        fifo_reset;
  logic        fifo_empty;
  logic [63:0] fifo_r_data;
  logic        fifo_rd;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_sop;
  logic        out_eop;
  logic [7:0]  msg_type;
  logic [15:0] msg_len;
  logic [31:0] msg_seq;
  logic        seq_gap;
  logic        err_sync;
  logic        err_len;
  logic [31:0] stat_msgs;
  logic [31:0] stat_errs;
  logic [1:0]  dbg_state;

  msg_word_parser dut (
    .fifo_clk   (fifo_clk),
    .fifo_reset (fifo_reset),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_rd    (fifo_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .msg_type   (msg_type),
    .msg_len    (msg_len),
    .msg_seq    (msg_seq),
    .seq_gap    (seq_gap),
    .err_sync   (err_sync),
    .err_len    (err_len),
    .stat_msgs  (stat_msgs),
    .stat_errs  (stat_errs),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [63:0]   fq[$];     // upstream FIFO contents
  logic [63:0]   mq[$];     // words not yet consumed by the model
  logic [BW-1:0] exp_q[$];  // expected beats

  bit          m_seen = 0;
  logic [31:0] m_exp_seq = '0;
  int exp_sync = 0, exp_len = 0, exp_msgs = 0, exp_errs = 0;
  int obs_sync = 0, obs_len = 0;

  int          cap_nbeats = 0;
  logic [7:0]  cap_first_keep = '0;
  logic [7:0]  cap_eop_keep = '0;
  logic        cap_sop_eop = 1'b0;
  logic [7:0]  cap_type = '0;
  logic [15:0] cap_len = '0;
  logic        cap_gap = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void drive_fifo();
    fifo_empty  = (fq.size() == 0);
    fifo_r_data = (fq.size() != 0) ? fq[0] : 64'd0;
  endfunction

  // ---------------- stream model ----------------
  task automatic model_run();
    logic [63:0] h, w;
    logic [15:0] len;
    logic        gap;
    logic [7:0]  keep;
    int n;
    while (mq.size() > 0) begin
      h = mq.pop_front();
      if (h[63:56] != 8'h7E) begin
        exp_sync++; exp_errs++;
        continue;
      end
      len = h[47:32];
      n = (int'(len) + 7) / 8;
      if (len == 0 || len > 1500) begin
        exp_len++; exp_errs++;
        for (int i = 0; i < n; i++) if (mq.size() > 0) void'(mq.pop_front());
        continue;
      end
      gap = m_seen && (h[31:0] != m_exp_seq);
      m_seen = 1;
      m_exp_seq = h[31:0] + 32'd1;
      for (int i = 0; i < n; i++) begin
        w = mq.pop_front();
        keep = 8'hFF;
        if (i == n - 1 && (len % 8) != 0) keep = 8'hFF >> (8 - (len % 8));
        exp_q.push_back({w, keep, 1'(i == 0), 1'(i == n - 1), h[55:48], len, h[31:0],
                         1'(gap && i == 0)});
      end
      exp_msgs++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [63:0] w);
    fq.push_back(w);
    mq.push_back(w);
    drive_fifo();
  endtask

  task automatic send_msg(input logic [7:0] sync, input logic [7:0] typ, input logic [15:0] len,
                          input logic [31:0] seq, input int nwords);
    push_word({sync, typ, len, seq});
    for (int i = 0; i < nwords; i++) push_word({$urandom, $urandom});
    model_run();
  endtask

  task automatic wait_idle(input bit rand_ready);
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge fifo_clk);
      n++;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: fifo words %0d expected beats %0d", fq.size(), exp_q.size());
    end
    repeat (3) @(negedge fifo_clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge fifo_clk);
      n++;
    end
    check("wait_valid", out_valid, 1);
  endtask

  // ---------------- upstream FIFO ----------------
  always @(posedge fifo_clk) begin
    if (fifo_rd) begin
      if (fq.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_when_empty: fifo_rd 1 with 0 words");
      end else begin
        void'(fq.pop_front());
      end
    end
    #1 drive_fifo();
  end

  // ---------------- scoreboard / compare ----------------
  logic [BW-1:0] held;
  bit            hv = 0;

  always @(negedge fifo_clk) begin
    logic [BW-1:0] got, exp;
    if (fifo_reset) begin
      hv = 0;
    end else begin
      got = {out_data, out_keep, out_sop, out_eop, msg_type, msg_len, msg_seq, seq_gap & out_sop};
      if (fifo_rd && fifo_empty) begin
        checks++; errors++;
        $display("FAIL rd_while_empty: fifo_rd 1 fifo_empty 1");
      end
      if (hv) begin
        checks++;
        if (!out_valid || got !== held) begin
          errors++;
          $display("FAIL hold: got %0h valid %0b expected %0h", got, out_valid, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: got %0h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL beat: got %0h expected %0h", got, exp);
          end
        end
        if (out_sop) begin
          cap_nbeats = 0;
          cap_first_keep = out_keep;
          cap_type = msg_type;
          cap_len = msg_len;
          cap_gap = seq_gap;
        end
        cap_nbeats++;
        if (out_eop) begin
          cap_eop_keep = out_keep;
          cap_sop_eop = out_sop;
        end
      end
      hv = out_valid && !out_ready;
      held = got;
      if (err_sync) obs_sync++;
      if (err_len) obs_len++;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    fifo_reset = 1'b1;
    out_ready  = 1'b1;
    drive_fifo();
    repeat (3) @(negedge fifo_clk);
    check("rst_valid", out_valid, 0);
    check("rst_rd", fifo_rd, 0);
    check("rst_sop_eop", {out_sop, out_eop, seq_gap}, 0);
    check("rst_err", {err_sync, err_len}, 0);
    check("rst_fields", {msg_type, msg_len, msg_seq}, 0);
    check("rst_stats", {stat_msgs, stat_errs}, 0);
    check("rst_state", dbg_state, 0);
    fifo_reset = 1'b0;
    @(negedge fifo_clk);

    // basic two-word message
    send_msg(8'h7E, 8'h05, 16'd16, 32'd1, 2);
    wait_idle(0);
    check("t1_beats", cap_nbeats, 2);
    check("t1_keep", {cap_first_keep, cap_eop_keep}, 16'hFFFF);
    check("t1_type_len", {cap_type, cap_len}, {8'h05, 16'd16});
    check("t1_gap", cap_gap, 0);

    // partial last word, then single-word message
    send_msg(8'h7E, 8'h06, 16'd13, 32'd2, 2);
    wait_idle(0);
    check("len13_beats", cap_nbeats, 2);
    check("len13_keep", cap_eop_keep, 8'h1F);
    send_msg(8'h7E, 8'h07, 16'd8, 32'd3, 1);
    wait_idle(0);
    check("len8_single", {cap_nbeats[7:0], cap_sop_eop, cap_eop_keep}, {8'd1, 1'b1, 8'hFF});

    // bad sync: one word consumed, nothing emitted
    send_msg(8'h55, 8'h01, 16'd16, 32'd0, 0);
    wait_idle(0);
    check("sync_err_count", obs_sync, 1);
    check("sync_one_pop", fq.size(), 0);
    send_msg(8'h7E, 8'h08, 16'd16, 32'd4, 2);
    wait_idle(0);
    check("after_sync_gap", cap_gap, 0);

    // oversize length: 250 words dropped silently
    send_msg(8'h7E, 8'h09, 16'd2000, 32'd1000, 250);
    wait_idle(0);
    check("len_err_count", obs_len, 1);
    check("len_drop_all", fq.size(), 0);
    send_msg(8'h7E, 8'h0A, 16'd24, 32'd5, 3);
    wait_idle(0);
    check("after_drop_gap", cap_gap, 0);
    check("after_drop_beats", cap_nbeats, 3);

    // sequence continuity
    send_msg(8'h7E, 8'h0B, 16'd8, 32'd1, 1);
    wait_idle(0);
    send_msg(8'h7E, 8'h0B, 16'd8, 32'd3, 1);
    wait_idle(0);
    check("seq3_gap", cap_gap, 1);
    send_msg(8'h7E, 8'h0B, 16'd8, 32'd4, 1);
    wait_idle(0);
    check("seq4_gap", cap_gap, 0);

    // downstream stall mid-message
    out_ready = 1'b0;
    send_msg(8'h7E, 8'h10, 16'd32, 32'd5, 4);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge fifo_clk);
      check("stall_no_rd", fifo_rd, 0);
      check("stall_sop_held", {out_valid, out_sop}, 2'b11);
    end
    out_ready = 1'b1;
    wait_idle(0);

    // next header consumed while previous eop is held
    out_ready = 1'b0;
    send_msg(8'h7E, 8'h21, 16'd8, 32'd6, 1);
    send_msg(8'h7E, 8'h22, 16'd5, 32'd7, 1);
    repeat (6) @(negedge fifo_clk);
    check("hdr_under_stall", fq.size(), 1);
    check("held_fields", {msg_type, msg_len}, {8'h21, 16'd8});
    out_ready = 1'b1;
    wait_idle(0);
    check("b2b_keep", {cap_type, cap_eop_keep}, {8'h22, 8'h1F});

    // irregular ready
    send_msg(8'h7E, 8'h23, 16'd44, 32'd8, 6);
    wait_idle(1);
    check("rand_keep", cap_eop_keep, 8'h0F);

    check("sync_total", obs_sync, exp_sync);
    check("len_total", obs_len, exp_len);
`ifdef PARSER_STATS_EN
    check("stat_msgs", stat_msgs, exp_msgs);
    check("stat_errs", stat_errs, exp_errs);
`else
    check("stat_off", {stat_msgs, stat_errs}, 0);
`endif

    // reset in the middle of a payload
    out_ready = 1'b0;
    send_msg(8'h7E, 8'h30, 16'd32, 32'd9, 4);
    wait_valid();
    #2 fifo_reset = 1'b1;
    @(negedge fifo_clk);
    check("mid_rst_out", {out_valid, out_sop, out_eop, seq_gap}, 0);
    check("mid_rst_rd", fifo_rd, 0);
    check("mid_rst_fields", {msg_type, msg_len, msg_seq}, 0);
    check("mid_rst_stats", {stat_msgs, stat_errs}, 0);
    check("mid_rst_state", dbg_state, 0);
    fq.delete();
    mq.delete();
    exp_q.delete();
    drive_fifo();
    m_seen = 0;
    exp_sync = 0; exp_len = 0; exp_msgs = 0; exp_errs = 0;
    obs_sync = 0; obs_len = 0;
    @(negedge fifo_clk);
    fifo_reset = 1'b0;
    out_ready = 1'b1;
    @(negedge fifo_clk);

    send_msg(8'h7E, 8'h31, 16'd12, 32'd500, 2);
    wait_idle(0);
    check("post_rst_gap", cap_gap, 0);
    check("post_rst_msg", {cap_nbeats[7:0], cap_eop_keep}, {8'd2, 8'h0F});
`ifdef PARSER_STATS_EN
    check("post_rst_stat", stat_msgs, exp_msgs);
`else
    check("post_rst_stat", stat_msgs, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
